// File: rtl/serial_rca.sv
// Bit-serial ripple-carry adder: one full-adder slice plus a carry flop, one sum bit per clock.
// Optional signed-overflow output sa_Ovf is built only when SERIAL_RCA_OVF_EN is defined.
module serial_rca #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sa_A,
  input  logic [WIDTH-1:0] sa_B,
  input  logic             sa_Cin,
  input  logic             sa_start,
  output logic             sa_ready,
  output logic             sa_busy,
  output logic [WIDTH-1:0] sa_Sum,
  output logic             sa_Cout,
  output logic             sa_done,
`ifdef SERIAL_RCA_OVF_EN
  output logic             sa_Ovf,
`endif
  output logic [1:0]       sa_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic [CW-1:0]  cnt;
  logic           c;
  logic           s_bit, c_next, last, accept;
  logic [WIDTH-1:0] s_next;

  // Handshake: a request transfers on a rising edge where sa_start && sa_ready;
  // sa_start is ignored (not queued) whenever sa_ready is low.
  assign accept   = sa_start && (state_q == IDLE);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign s_bit    = a_sh[0] ^ b_sh[0] ^ c;
  assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign s_next   = {s_bit, s_sh[WIDTH-1:1]};

  assign sa_ready = (state_q == IDLE);
  assign sa_busy  = (state_q == SHIFT) || (state_q == DONE);
  assign sa_done  = (state_q == DONE);
  assign sa_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sa_start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      sa_Sum  <= '0;
      sa_Cout <= 1'b0;
`ifdef SERIAL_RCA_OVF_EN
      sa_Ovf  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= sa_A;
      b_sh <= sa_B;
      s_sh <= '0;
      c    <= sa_Cin;
      cnt  <= '0;
    end else if (state_q == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      s_sh <= s_next;
      c    <= c_next;
      cnt  <= cnt + 1'b1;
      if (last) begin
        sa_Sum  <= s_next;
        sa_Cout <= c_next;
`ifdef SERIAL_RCA_OVF_EN
        // c is the carry into the MSB slice, c_next the carry out of it.
        sa_Ovf  <= c ^ c_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_rca.sv
// Self-checking bench for serial_rca: scoreboard queue of {ovf,cout,sum} pushed at acceptance,
// popped on sa_done; also checks latency, throughput, result hold and reset behaviour.
module tb_serial_rca;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] sa_A = '0;
  logic [WIDTH-1:0] sa_B = '0;
  logic             sa_Cin = 1'b0;
  logic             sa_start = 1'b0;
  logic             sa_ready, sa_busy, sa_Cout, sa_done;
  logic [WIDTH-1:0] sa_Sum;
  logic [1:0]       sa_state;
`ifdef SERIAL_RCA_OVF_EN
  logic             sa_Ovf;
`endif

  serial_rca #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .sa_A(sa_A), .sa_B(sa_B), .sa_Cin(sa_Cin),
    .sa_start(sa_start), .sa_ready(sa_ready), .sa_busy(sa_busy),
    .sa_Sum(sa_Sum), .sa_Cout(sa_Cout), .sa_done(sa_done),
`ifdef SERIAL_RCA_OVF_EN
    .sa_Ovf(sa_Ovf),
`endif
    .sa_state(sa_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // scoreboard
  logic [WIDTH+1:0] exp_q[$];
  int acc_cyc = 0;
  bit acc_valid = 0;
  int last_acc = -1;
  bit b2b = 0;
  int done_cnt = 0;
  bit prev_ready = 1;
  logic [WIDTH-1:0] prev_sum = '0;
  logic prev_cout = 1'b0;

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin);
    logic [WIDTH:0] full;
    logic ovf;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {ovf, full};
  endfunction

  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    if (rst) begin
      exp_q.delete();
      acc_valid = 0;
      prev_ready = 1;
    end else begin
      if (sa_done) begin
        done_cnt++;
        check_eq("done_has_expect", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sum", sa_Sum, e[WIDTH-1:0]);
          check_eq("cout", sa_Cout, e[WIDTH]);
`ifdef SERIAL_RCA_OVF_EN
          check_eq("ovf", sa_Ovf, e[WIDTH+1]);
`endif
          check_eq("done_lat", cyc - acc_cyc, WIDTH);
        end
      end else begin
        check_eq("sum_hold", sa_Sum, prev_sum);
        check_eq("cout_hold", sa_Cout, prev_cout);
      end
      if (sa_ready && !prev_ready && acc_valid)
        check_eq("ready_lat", cyc - acc_cyc, WIDTH + 1);
      check_eq("busy_vs_ready", sa_busy, !sa_ready);
      if (sa_start && sa_ready) begin
        exp_q.push_back(model(sa_A, sa_B, sa_Cin));
        if (b2b && last_acc >= 0) check_eq("b2b_gap", cyc + 1 - last_acc, WIDTH + 2);
        last_acc = cyc + 1;
        acc_cyc = cyc + 1;
        acc_valid = 1;
      end
      prev_ready = sa_ready;
    end
    prev_sum = sa_Sum;
    prev_cout = sa_Cout;
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    sa_A = a;
    sa_B = b;
    sa_Cin = cin;
    sa_start = 1'b1;
    tick();
    sa_start = 1'b0;
    sa_A = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    sa_B = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
  endtask

  task automatic wait_idle;
    bit ok = 0;
    for (int i = 0; i < 4 * WIDTH + 10; i++) begin
      if (exp_q.size() == 0 && sa_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    check_eq("idle_timeout", ok, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check_eq({tag, "_ready"}, sa_ready, 1);
    check_eq({tag, "_busy"}, sa_busy, 0);
    check_eq({tag, "_done"}, sa_done, 0);
    check_eq({tag, "_sum"}, sa_Sum, 0);
    check_eq({tag, "_cout"}, sa_Cout, 0);
`ifdef SERIAL_RCA_OVF_EN
    check_eq({tag, "_ovf"}, sa_Ovf, 0);
`endif
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    check_reset_outputs("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // directed adds
    start_op(8'h5A, 8'h33, 1'b0);
    wait_idle();
    check_eq("basic_sum", sa_Sum, 8'h8D);
    start_op(8'hFF, 8'h01, 1'b0);
    wait_idle();
    check_eq("cout_case", {sa_Cout, sa_Sum}, 9'h100);
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_idle();
    check_eq("cin_case", {sa_Cout, sa_Sum}, 9'h1FF);

    // start ignored while busy
    d0 = done_cnt;
    start_op(8'h01, 8'h01, 1'b0);
    tick();
    tick();
    tick();
    start_op(8'h10, 8'h10, 1'b0);
    wait_idle();
    repeat (4) tick();
    check_eq("ignored_done_cnt", done_cnt - d0, 1);
    check_eq("ignored_sum", sa_Sum, 8'h02);

    // back-to-back with start held high and changing operands
    last_acc = -1;
    b2b = 1;
    d0 = done_cnt;
    sa_start = 1'b1;
    for (int i = 0; i < 6 * (WIDTH + 2); i++) begin
      sa_A = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      sa_B = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      sa_Cin = 1'($urandom_range(0, 1));
      tick();
    end
    sa_start = 1'b0;
    wait_idle();
    b2b = 0;
    check_eq("b2b_done_cnt", done_cnt - d0, 6);

    // reset in the middle of an operation
    start_op(8'hC3, 8'h7E, 1'b1);
    tick();
    tick();
    tick();
    d0 = done_cnt;
    rst = 1'b1;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    repeat (WIDTH + 4) tick();
    check_eq("midrst_no_done", done_cnt - d0, 0);
    check_eq("midrst_sum", sa_Sum, 0);
    start_op(8'h80, 8'h80, 1'b0);
    wait_idle();
    check_eq("post_rst_res", {sa_Cout, sa_Sum}, 9'h100);

    // random operations with random gaps
    for (int i = 0; i < 20; i++) begin
      start_op(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)),
               WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'($urandom_range(0, 1)));
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
